// File: rtl/cdc_bus_filter_sync.sv
// cdc_bus_filter_sync: brings WIDTH independent asynchronous control bits
// into the clk domain through a flop chain. Each bit then passes a
// stability filter, and the block emits rise/fall pulses on accepted changes.
// Ports:
//   clk        destination clock, rising edge
//   rst        synchronous active-high reset
//   async_in   [WIDTH] asynchronous inputs
//   sync_out   [WIDTH] filtered synchronised levels
//   rise_pulse [WIDTH] one-cycle pulse on sync_out 0->1
//   fall_pulse [WIDTH] one-cycle pulse on sync_out 1->0
//   any_change OR of all rise/fall pulses, same cycle
module cdc_bus_filter_sync #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      FILTER_LEN  = 4,
  parameter logic [WIDTH-1:0] INIT_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  localparam int unsigned CW =
    (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Chain flops kept adjacent by placement; nothing sits between them.
  (* ASYNC_REG = "TRUE" *)
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_any;

  logic [WIDTH-1:0] w_sv;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_fire;

  assign w_sv   = r_sync[SYNC_STAGES-1];
  assign w_diff = w_sv ^ r_out;

  // A channel fires once its new value has been seen FILTER_LEN times.
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_fire[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= INIT_VAL;
      end
    end else begin
      r_sync[0] <= async_in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
      r_out  <= INIT_VAL;
      r_rise <= '0;
      r_fall <= '0;
      r_any  <= 1'b0;
    end else begin
      // Counter restarts whenever the level matches or a change lands.
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (!w_diff[i] || w_fire[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
      r_out  <= r_out ^ w_fire;
      r_rise <= w_fire & w_sv;
      r_fall <= w_fire & ~w_sv;
      r_any  <= |w_fire;
    end
  end

  assign sync_out   = r_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign any_change = r_any;

endmodule

// File: tb/tb_cdc_bus_filter_sync.sv
// tb_cdc_bus_filter_sync: directed and randomized checks of the
// multi-channel synchroniser / glitch filter.
module tb_cdc_bus_filter_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        rst_a, rst_d, rst_f, rst_r;
  logic [7:0]  in_a, in_d, in_f;
  logic [15:0] in_r;
  logic [7:0]  out_a, rise_a, fall_a;
  logic [7:0]  out_d, rise_d, fall_d;
  logic [7:0]  out_f, rise_f, fall_f;
  logic [15:0] out_r, rise_r, fall_r;
  logic        any_a, any_d, any_f, any_r;

  cdc_bus_filter_sync #(
    .WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(4), .INIT_VAL(8'hA5)
  ) u_a5 (
    .clk(clk), .rst(rst_a), .async_in(in_a), .sync_out(out_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
  );

  cdc_bus_filter_sync #(
    .WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(4), .INIT_VAL(8'h00)
  ) u_def (
    .clk(clk), .rst(rst_d), .async_in(in_d), .sync_out(out_d),
    .rise_pulse(rise_d), .fall_pulse(fall_d), .any_change(any_d)
  );

  cdc_bus_filter_sync #(
    .WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(1), .INIT_VAL(8'h00)
  ) u_f1 (
    .clk(clk), .rst(rst_f), .async_in(in_f), .sync_out(out_f),
    .rise_pulse(rise_f), .fall_pulse(fall_f), .any_change(any_f)
  );

  cdc_bus_filter_sync #(
    .WIDTH(16), .SYNC_STAGES(3), .FILTER_LEN(8), .INIT_VAL(16'h0000)
  ) u_rnd (
    .clk(clk), .rst(rst_r), .async_in(in_r), .sync_out(out_r),
    .rise_pulse(rise_r), .fall_pulse(fall_r), .any_change(any_r)
  );

  localparam int N = 800;
  localparam int RSS = 3;
  localparam int RFL = 8;
  logic [15:0] hist [N];
  logic [15:0] mo [N];
  logic [15:0] mr [N];
  logic [15:0] mf [N];
  logic [15:0] ao [N];
  logic [15:0] ar [N];
  logic [15:0] af [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_d(input logic [7:0] v);
    in_d = v;
    repeat (12) tick();
  endtask

  // Input value sampled at edge k; edges before release look like INIT.
  function automatic logic [15:0] hf(input int k);
    if (k < 0) return 16'h0000;
    return hist[k];
  endfunction

  task automatic test_reset();
    int fe, fc, ac, rc;
    in_a = 8'h00;
    rst_a = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_a !== 8'hA5 || rise_a !== 8'h00 ||
          fall_a !== 8'h00 || any_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold c=%0d out=%h r=%h f=%h any=%b req out=a5 pulses=0",
                 c, out_a, rise_a, fall_a, any_a);
      end
    end
    rst_a = 1'b0;
    fe = -1; fc = 0; ac = 0; rc = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (fall_a !== 8'h00) begin
        fc++;
        if (fe < 0) fe = e;
        checks++;
        if (fall_a !== 8'hA5) begin
          failures++;
          $display("FAIL reset_fall_val got=%h req=a5", fall_a);
        end
      end
      if (any_a !== 1'b0) ac++;
      if (rise_a !== 8'h00) rc++;
      if (e < 4) begin
        checks++;
        if (out_a !== 8'hA5) begin
          failures++;
          $display("FAIL reset_early_out e=%0d got=%h req=a5", e, out_a);
        end
      end
    end
    checks++;
    if (fe < 4 || fe > 6) begin
      failures++;
      $display("FAIL reset_fall_edge got=%0d req=5+-1", fe);
    end
    checks++;
    if (fc != 1) begin
      failures++;
      $display("FAIL reset_fall_cnt got=%0d req=1", fc);
    end
    checks++;
    if (ac != 1) begin
      failures++;
      $display("FAIL reset_any_cnt got=%0d req=1", ac);
    end
    checks++;
    if (rc != 0) begin
      failures++;
      $display("FAIL reset_rise_cnt got=%0d req=0", rc);
    end
    checks++;
    if (out_a !== 8'h00) begin
      failures++;
      $display("FAIL reset_final_out got=%h req=00", out_a);
    end
  endtask

  task automatic test_latency();
    int re, rc, fc;
    in_d = 8'h00;
    rst_d = 1'b1;
    tick(); tick();
    rst_d = 1'b0;
    tick(); tick(); tick();
    in_d = 8'h08;
    re = -1; rc = 0; fc = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (rise_d !== 8'h00) begin
        rc++;
        if (re < 0) re = e;
        checks++;
        if (rise_d !== 8'h08) begin
          failures++;
          $display("FAIL lat_rise_val got=%h req=08", rise_d);
        end
      end
      if (fall_d !== 8'h00) fc++;
    end
    checks++;
    if (re < 4 || re > 6 || rc != 1 || fc != 0) begin
      failures++;
      $display("FAIL lat_def edge=%0d rises=%0d falls=%0d req edge=5+-1 rises=1 falls=0",
               re, rc, fc);
    end
    checks++;
    if (out_d !== 8'h08) begin
      failures++;
      $display("FAIL lat_def_out got=%h req=08", out_d);
    end

    in_f = 8'h00;
    tick();
    rst_f = 1'b0;
    tick(); tick();
    in_f = 8'h08;
    re = -1; rc = 0; fc = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (rise_f !== 8'h00) begin
        rc++;
        if (re < 0) re = e;
        checks++;
        if (rise_f !== 8'h08) begin
          failures++;
          $display("FAIL lat_f1_val got=%h req=08", rise_f);
        end
      end
      if (fall_f !== 8'h00 || any_f !== (rise_f != 8'h00)) fc++;
    end
    checks++;
    if (re < 1 || re > 3 || rc != 1 || fc != 0) begin
      failures++;
      $display("FAIL lat_f1 edge=%0d rises=%0d bad=%0d req edge=2+-1 rises=1 bad=0",
               re, rc, fc);
    end
    checks++;
    if (out_f !== 8'h08) begin
      failures++;
      $display("FAIL lat_f1_out got=%h req=08", out_f);
    end
  endtask

  task automatic test_glitch();
    int re, fe, rc, fc, oc;
    settle_d(8'h00);
    for (int e = 0; e < 18; e++) begin
      in_d = (e < 3) ? 8'h02 : 8'h00;
      tick();
      checks++;
      if (out_d !== 8'h00 || rise_d !== 8'h00 ||
          fall_d !== 8'h00 || any_d !== 1'b0) begin
        failures++;
        $display("FAIL glitch3 e=%0d out=%h r=%h f=%h any=%b req all 0",
                 e, out_d, rise_d, fall_d, any_d);
      end
    end
    re = -1; fe = -1; rc = 0; fc = 0; oc = 0;
    for (int e = 0; e < 25; e++) begin
      in_d = (e < 6) ? 8'h02 : 8'h00;
      tick();
      if (rise_d[1]) begin rc++; if (re < 0) re = e; end
      if (fall_d[1]) begin fc++; if (fe < 0) fe = e; end
      if ((rise_d | fall_d) & 8'hFD) oc++;
    end
    checks++;
    if (rc != 1 || fc != 1 || oc != 0) begin
      failures++;
      $display("FAIL glitch6_cnt rises=%0d falls=%0d other=%0d req 1 1 0",
               rc, fc, oc);
    end
    checks++;
    if (re < 4 || re > 6 || fe < 10 || fe > 12) begin
      failures++;
      $display("FAIL glitch6_edges rise=%0d fall=%0d req 5+-1 11+-1", re, fe);
    end
  endtask

  task automatic test_simultaneous();
    int pc, ac, fc;
    settle_d(8'h00);
    in_d = 8'hFF;
    pc = 0; ac = 0; fc = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (rise_d !== 8'h00) begin
        pc++;
        checks++;
        if (rise_d !== 8'hFF) begin
          failures++;
          $display("FAIL simul_rise_val got=%h req=ff", rise_d);
        end
      end
      if (any_d !== 1'b0) ac++;
      if (fall_d !== 8'h00) fc++;
    end
    checks++;
    if (pc != 1 || ac != 1 || fc != 0) begin
      failures++;
      $display("FAIL simul_cnt rise_cyc=%0d any_cyc=%0d fall_cyc=%0d req 1 1 0",
               pc, ac, fc);
    end
    checks++;
    if (out_d !== 8'hFF) begin
      failures++;
      $display("FAIL simul_out got=%h req=ff", out_d);
    end
    settle_d(8'h00);
  endtask

  task automatic test_reset_midcount();
    int re, rc;
    settle_d(8'h00);
    in_d = 8'h04;
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if (rise_d !== 8'h00 || out_d !== 8'h00) begin
        failures++;
        $display("FAIL mid_pre e=%0d out=%h r=%h req 00 00", e, out_d, rise_d);
      end
    end
    rst_d = 1'b1;
    tick();
    rst_d = 1'b0;
    checks++;
    if (rise_d !== 8'h00 || fall_d !== 8'h00 ||
        any_d !== 1'b0 || out_d !== 8'h00) begin
      failures++;
      $display("FAIL mid_rst out=%h r=%h f=%h any=%b req all 0",
               out_d, rise_d, fall_d, any_d);
    end
    re = -1; rc = 0;
    for (int r = 0; r < 12; r++) begin
      tick();
      if (rise_d !== 8'h00) begin rc++; if (re < 0) re = r; end
      if (r < 4) begin
        checks++;
        if (out_d[2] !== 1'b0) begin
          failures++;
          $display("FAIL mid_hold r=%0d out2=%b req 0", r, out_d[2]);
        end
      end
    end
    checks++;
    if (rc != 1 || re < 4 || re > 6) begin
      failures++;
      $display("FAIL mid_rise rises=%0d edge=%0d req 1 at 5+-1", rc, re);
    end
  endtask

  task automatic test_random();
    int hold [16];
    logic [15:0] cur, prev, allx, m0, m2, ap, bad;
    int qa [$];
    int qm [$];
    int da;
    cur = 16'h0000;
    for (int c = 0; c < 16; c++) hold[c] = $urandom_range(1, 20);
    in_r = 16'h0000;
    tick();
    rst_r = 1'b0;
    for (int n = 0; n < N; n++) begin
      for (int c = 0; c < 16; c++) begin
        if (hold[c] == 0) begin
          cur[c] = ~cur[c];
          hold[c] = $urandom_range(1, 20);
        end
        hold[c]--;
      end
      in_r = cur;
      hist[n] = cur;
      tick();
      // Change lands once the last RFL filtered samples all differ.
      prev = (n > 0) ? mo[n-1] : 16'h0000;
      allx = 16'hFFFF;
      for (int j = 0; j < RFL; j++) allx &= hf(n - j - RSS) ^ prev;
      mo[n] = prev ^ allx;
      mr[n] = allx & mo[n];
      mf[n] = allx & ~mo[n];
      ao[n] = out_r;
      ar[n] = rise_r;
      af[n] = fall_r;
      checks++;
      if (any_r !== |(rise_r | fall_r) || (rise_r & fall_r) !== 16'h0) begin
        failures++;
        $display("FAIL rnd_any n=%0d any=%b r=%h f=%h req any=OR, no overlap",
                 n, any_r, rise_r, fall_r);
      end
    end
    for (int n = 0; n < N; n++) begin
      m0 = (n > 0) ? mo[n-1] : 16'h0000;
      m2 = (n < N-1) ? mo[n+1] : mo[n];
      bad = (ao[n] ^ mo[n]) & (ao[n] ^ m0) & (ao[n] ^ m2);
      checks++;
      if (bad !== 16'h0000) begin
        failures++;
        $display("FAIL rnd_out n=%0d got=%h req=%h (+-1) badbits=%h",
                 n, ao[n], mo[n], bad);
      end
      ap = (n > 0) ? ao[n-1] : 16'h0000;
      checks++;
      if (ar[n] !== (ao[n] & ~ap) || af[n] !== (~ao[n] & ap)) begin
        failures++;
        $display("FAIL rnd_pulse_match n=%0d r=%h f=%h req r=%h f=%h",
                 n, ar[n], af[n], ao[n] & ~ap, ~ao[n] & ap);
      end
    end
    for (int c = 0; c < 16; c++) begin
      qa.delete();
      qm.delete();
      for (int n = 0; n < N; n++) begin
        if (ar[n][c]) qa.push_back(n * 2 + 1);
        if (af[n][c]) qa.push_back(n * 2);
        if (mr[n][c]) qm.push_back(n * 2 + 1);
        if (mf[n][c]) qm.push_back(n * 2);
      end
      checks++;
      if (qa.size() != qm.size()) begin
        failures++;
        $display("FAIL rnd_evcnt ch=%0d got=%0d req=%0d",
                 c, qa.size(), qm.size());
      end else begin
        for (int k = 0; k < qa.size(); k++) begin
          da = qa[k] / 2 - qm[k] / 2;
          checks++;
          if ((qa[k] % 2) != (qm[k] % 2) || da > 1 || da < -1) begin
            failures++;
            $display("FAIL rnd_event ch=%0d k=%0d got t=%0d dir=%0d req t=%0d dir=%0d",
                     c, k, qa[k] / 2, qa[k] % 2, qm[k] / 2, qm[k] % 2);
          end
        end
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_d = 1'b1; rst_f = 1'b1; rst_r = 1'b1;
    in_a = 8'h00; in_d = 8'h00; in_f = 8'h00; in_r = 16'h0000;
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
